// File: rtl/mem_wb_skid_stage.sv
// MEM->WB elastic stage: output register O plus one skid register S (2-entry FIFO),
// registered m_ready, synchronous flush, write-back result mux and retire counter.
module mem_wb_skid_stage #(
    parameter int XLEN  = 32,
    parameter int RW    = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,

    input  logic             m_valid,
    output logic             m_ready,
    input  logic             RegWriteM,
    input  logic [1:0]       ResultSrcM,
    input  logic [XLEN-1:0]  AluResultM,
    input  logic [XLEN-1:0]  RD,
    input  logic [XLEN-1:0]  pc_plus_fourM,
    input  logic [RW-1:0]    RdM,

    output logic             w_valid,
    input  logic             w_ready,
    output logic             RegWriteW,
    output logic [1:0]       ResultSrcW,
    output logic [XLEN-1:0]  ALUResult,
    output logic [XLEN-1:0]  ReadDataW,
    output logic [XLEN-1:0]  pc_plus_fourW,
    output logic [RW-1:0]    RdW,
    output logic [XLEN-1:0]  ResultW,
    output logic [CNT_W-1:0] retire_count
);

    typedef struct packed {
        logic            reg_write;
        logic [1:0]      result_src;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] read_data;
        logic [XLEN-1:0] pc_plus_four;
        logic [RW-1:0]   rd;
    } payload_t;

    payload_t        in_p, o_q, s_q;
    logic            o_v, s_v;
    logic [CNT_W-1:0] cnt_q;

    logic accept, drain;
    logic o_load_in, o_load_skid, s_load;
    logic o_v_nxt, s_v_nxt;

    assign in_p = '{
        reg_write:    RegWriteM,
        result_src:   ResultSrcM,
        alu_result:   AluResultM,
        read_data:    RD,
        pc_plus_four: pc_plus_fourM,
        rd:           RdM
    };

    // s_v is a flop, so the MEM side never sees a combinational path from w_ready.
    assign m_ready = reset & ~s_v;
    assign accept  = m_valid & m_ready;
    assign drain   = o_v & w_ready;

    always_comb begin
        o_load_in   = 1'b0;
        o_load_skid = 1'b0;
        s_load      = 1'b0;
        o_v_nxt     = o_v;
        s_v_nxt     = s_v;
        if (flush) begin
            o_v_nxt = 1'b0;
            s_v_nxt = 1'b0;
        end else if (!o_v || drain) begin
            if (s_v) begin
                o_load_skid = 1'b1;
                o_v_nxt     = 1'b1;
                s_load      = accept;
                s_v_nxt     = accept;
            end else begin
                o_load_in = accept;
                o_v_nxt   = accept;
            end
        end else if (accept) begin
            s_load  = 1'b1;
            s_v_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            o_v <= 1'b0;
            s_v <= 1'b0;
        end else begin
            o_v <= o_v_nxt;
            s_v <= s_v_nxt;
        end
    end

    // Payload is left alone by flush; only the valid bits are dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            o_q <= '0;
            s_q <= '0;
        end else begin
            if (o_load_skid)    o_q <= s_q;
            else if (o_load_in) o_q <= in_p;
            if (s_load)         s_q <= in_p;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)     cnt_q <= '0;
        else if (drain) cnt_q <= cnt_q + CNT_W'(1);
    end

    always_comb begin
        ResultW = '0;
        case (o_q.result_src)
            2'b00:   ResultW = o_q.alu_result;
            2'b01:   ResultW = o_q.read_data;
            2'b10:   ResultW = o_q.pc_plus_four;
            default: ResultW = '0;
        endcase
    end

    assign w_valid       = o_v;
    assign RegWriteW     = o_q.reg_write & o_v & (o_q.rd != '0);
    assign ResultSrcW    = o_q.result_src;
    assign ALUResult     = o_q.alu_result;
    assign ReadDataW     = o_q.read_data;
    assign pc_plus_fourW = o_q.pc_plus_four;
    assign RdW           = o_q.rd;
    assign retire_count  = cnt_q;

`ifndef SYNTHESIS
    // The skid slot can only be occupied behind a full output slot.
    always_ff @(posedge clk) begin
        if (reset) assert (!s_v || o_v);
    end
`endif

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Bench for mem_wb_skid_stage: directed table, hand sequences, and a random run
// against a queue-based reference model; a CNT_W=4 twin checks counter wrap.
module tb_mem_wb_skid_stage;

    typedef struct packed {
        logic        rw;
        logic [1:0]  src;
        logic [31:0] alu;
        logic [31:0] rdat;
        logic [31:0] pc;
        logic [4:0]  rd;
    } ent_t;

    typedef struct packed {
        logic        wv;
        logic        mr;
        logic        rww;
        logic [1:0]  src;
        logic [31:0] alu;
        logic [31:0] rdat;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] res;
    } obs_t;

    typedef struct {
        logic        fl, mv, wr;
        ent_t        e;
        logic        ewv, emr, erw;
        logic [31:0] eres;
        int          ecnt;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, fl, mv, wr;
    ent_t cur;

    logic        mr0, wv0, rww0, mr1, wv1, rww1;
    logic [1:0]  src0, src1;
    logic [31:0] alu0, rdat0, pc0, res0, alu1, rdat1, pc1, res1;
    logic [4:0]  rd0, rd1;
    logic [31:0] cnt0;
    logic [3:0]  cnt1;
    obs_t        o0, o1;

    int checks = 0;
    int errors = 0;

    mem_wb_skid_stage dut (
        .clk(clk), .reset(rst), .flush(fl),
        .m_valid(mv), .m_ready(mr0),
        .RegWriteM(cur.rw), .ResultSrcM(cur.src), .AluResultM(cur.alu),
        .RD(cur.rdat), .pc_plus_fourM(cur.pc), .RdM(cur.rd),
        .w_valid(wv0), .w_ready(wr), .RegWriteW(rww0), .ResultSrcW(src0),
        .ALUResult(alu0), .ReadDataW(rdat0), .pc_plus_fourW(pc0), .RdW(rd0),
        .ResultW(res0), .retire_count(cnt0)
    );

    mem_wb_skid_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(rst), .flush(fl),
        .m_valid(mv), .m_ready(mr1),
        .RegWriteM(cur.rw), .ResultSrcM(cur.src), .AluResultM(cur.alu),
        .RD(cur.rdat), .pc_plus_fourM(cur.pc), .RdM(cur.rd),
        .w_valid(wv1), .w_ready(wr), .RegWriteW(rww1), .ResultSrcW(src1),
        .ALUResult(alu1), .ReadDataW(rdat1), .pc_plus_fourW(pc1), .RdW(rd1),
        .ResultW(res1), .retire_count(cnt1)
    );

    assign o0 = {wv0, mr0, rww0, src0, alu0, rdat0, pc0, rd0, res0};
    assign o1 = {wv1, mr1, rww1, src1, alu1, rdat1, pc1, rd1, res1};

    function automatic ent_t mk(logic rw, logic [1:0] src, logic [31:0] alu,
                                logic [31:0] rdat, logic [31:0] pc, logic [4:0] rd);
        ent_t e;
        e.rw = rw; e.src = src; e.alu = alu; e.rdat = rdat; e.pc = pc; e.rd = rd;
        return e;
    endfunction

    function automatic vec_t mv_row(logic f, logic m, logic w, ent_t e,
                                    logic ewv, logic emr, logic erw,
                                    logic [31:0] eres, int ecnt);
        vec_t v;
        v.fl = f; v.mv = m; v.wr = w; v.e = e;
        v.ewv = ewv; v.emr = emr; v.erw = erw; v.eres = eres; v.ecnt = ecnt;
        return v;
    endfunction

    function automatic logic [31:0] sel(ent_t e);
        if (e.src == 2'd0) return e.alu;
        if (e.src == 2'd1) return e.rdat;
        if (e.src == 2'd2) return e.pc;
        return 32'd0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic m,
                         input logic w, input ent_t e);
        rst = r; fl = f; mv = m; wr = w; cur = e;
    endtask

    task automatic chk_obs(input string tag, input obs_t o, input logic ewv,
                           input logic emr, input logic full, input ent_t e);
        chk({tag, ".w_valid"}, 64'(o.wv), 64'(ewv));
        chk({tag, ".m_ready"}, 64'(o.mr), 64'(emr));
        chk({tag, ".RegWriteW"}, 64'(o.rww), 64'(full && e.rw && e.rd != 5'd0));
        if (full) begin
            chk({tag, ".ResultSrcW"}, 64'(o.src), 64'(e.src));
            chk({tag, ".ALUResult"}, 64'(o.alu), 64'(e.alu));
            chk({tag, ".ReadDataW"}, 64'(o.rdat), 64'(e.rdat));
            chk({tag, ".pc_plus_fourW"}, 64'(o.pc), 64'(e.pc));
            chk({tag, ".RdW"}, 64'(o.rd), 64'(e.rd));
            chk({tag, ".ResultW"}, 64'(o.res), 64'(sel(e)));
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".outs0"}, 64'(o0), 64'd0);
        chk({tag, ".outs4"}, 64'(o1), 64'd0);
        chk({tag, ".cnt0"}, 64'(cnt0), 64'd0);
        chk({tag, ".cnt4"}, 64'(cnt1), 64'd0);
    endtask

    ent_t q[$];
    logic [31:0] mcnt;
    vec_t tbl[14];

    initial begin
        ent_t z, e2;
        z  = mk(1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        e2 = mk(1'b1, 2'd3, 32'd5, 32'd0, 32'd0, 5'd5);
        tbl[0]  = mv_row(0,1,0, mk(1,2'd1,32'd1,32'hDEADBEEF,32'd4,5'd3), 1,1,1, 32'hDEADBEEF, 0);
        tbl[1]  = mv_row(0,1,0, mk(1,2'd2,32'd2,32'd0,32'h104,5'd4),      1,0,1, 32'hDEADBEEF, 0);
        tbl[2]  = mv_row(0,1,0, e2,                                        1,0,1, 32'hDEADBEEF, 0);
        tbl[3]  = mv_row(0,1,1, e2,                                        1,1,1, 32'h104, 1);
        tbl[4]  = mv_row(0,1,1, e2,                                        1,1,1, 32'd0, 2);
        tbl[5]  = mv_row(0,1,1, mk(1,2'd0,32'h55,32'd0,32'd0,5'd0),        1,1,0, 32'h55, 3);
        tbl[6]  = mv_row(0,0,1, z,                                         0,1,0, 32'd0, 4);
        tbl[7]  = mv_row(0,1,0, mk(1,2'd0,32'h70,32'd0,32'd0,5'd1),        1,1,1, 32'h70, 4);
        tbl[8]  = mv_row(0,1,0, mk(1,2'd0,32'h71,32'd0,32'd0,5'd2),        1,0,1, 32'h70, 4);
        tbl[9]  = mv_row(1,1,0, mk(1,2'd0,32'h72,32'd0,32'd0,5'd3),        0,1,0, 32'd0, 4);
        tbl[10] = mv_row(0,1,0, mk(1,2'd0,32'h73,32'd0,32'd0,5'd6),        1,1,1, 32'h73, 4);
        tbl[11] = mv_row(0,1,0, mk(1,2'd0,32'h74,32'd0,32'd0,5'd7),        1,0,1, 32'h73, 4);
        tbl[12] = mv_row(1,1,1, mk(1,2'd0,32'h75,32'd0,32'd0,5'd8),        0,1,0, 32'd0, 5);
        tbl[13] = mv_row(0,0,0, z,                                         0,1,0, 32'd0, 5);

        // Reset held two cycles with m_valid high.
        drive(0, 0, 1, 1, mk(1, 2'd1, 32'hA5, 32'hB6, 32'hC7, 5'd9));
        repeat (2) @(posedge clk);
        #1 chk_reset_state("rst");
        @(negedge clk);
        drive(1, 0, 0, 0, z);
        #1;
        chk("rst.release.m_ready", 64'(mr0), 64'd1);
        chk("rst.release.w_valid", 64'(wv0), 64'd0);
        chk("rst.release.cnt", 64'(cnt0), 64'd0);

        // Back-to-back streaming.
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, i < 8, 1, mk(1, 2'd0, 32'h10 + 32'(i), 32'd0, 32'd0, 5'(i + 1)));
            @(posedge clk); #1;
            if (i < 8) begin
                chk("stream.w_valid", 64'(wv0), 64'd1);
                chk("stream.ResultW", 64'(res0), 64'h10 + 64'(i));
                chk("stream.RdW", 64'(rd0), 64'(i + 1));
            end else begin
                chk("stream.end.w_valid", 64'(wv0), 64'd0);
                chk("stream.end.cnt", 64'(cnt0), 64'd8);
            end
            @(negedge clk);
        end

        // Directed table: backpressure, result select, x0, flush.
        for (int i = 0; i < 14; i++) begin
            drive(1, tbl[i].fl, tbl[i].mv, tbl[i].wr, tbl[i].e);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d.w_valid", i), 64'(wv0), 64'(tbl[i].ewv));
            chk($sformatf("tbl%0d.m_ready", i), 64'(mr0), 64'(tbl[i].emr));
            chk($sformatf("tbl%0d.RegWriteW", i), 64'(rww0), 64'(tbl[i].erw));
            if (tbl[i].ewv)
                chk($sformatf("tbl%0d.ResultW", i), 64'(res0), 64'(tbl[i].eres));
            chk($sformatf("tbl%0d.cnt", i), 64'(cnt0), 64'(8 + tbl[i].ecnt));
            @(negedge clk);
        end

        // Reset mid-operation with both slots full and w_ready high.
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 1, 0, mk(1, 2'd0, 32'h90 + 32'(i), 32'd1, 32'd2, 5'd3));
            @(negedge clk);
        end
        chk("midrst.full.m_ready", 64'(mr0), 64'd0);
        drive(0, 0, 1, 1, z);
        repeat (2) @(posedge clk);
        #1 chk_reset_state("midrst");
        @(negedge clk);

        // 17 drains: the 4-bit twin wraps to 1.
        for (int i = 0; i < 18; i++) begin
            drive(1, 0, i < 17, 1, mk(1, 2'd0, 32'(i), 32'd0, 32'd0, 5'd1));
            @(negedge clk);
        end
        chk("wrap.cnt32", 64'(cnt0), 64'd17);
        chk("wrap.cnt4", 64'(cnt1), 64'd1);

        // Random traffic against the queue model.
        q.delete();
        mcnt = 32'd17;
        for (int n = 0; n < 3000; n++) begin
            ent_t e;
            logic r, f, m, w, acc, drn;
            e = mk(1'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
                   ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom));
            r = ($urandom_range(0, 63) != 0);
            f = ($urandom_range(0, 15) == 0);
            m = ($urandom_range(0, 9) < 7);
            w = ($urandom_range(0, 9) < 6);
            drive(r, f, m, w, e);
            #1;
            chk_obs("rnd.d32", o0, q.size() != 0, r && q.size() < 2, q.size() != 0,
                    (q.size() != 0) ? q[0] : z);
            chk_obs("rnd.d4", o1, q.size() != 0, r && q.size() < 2, q.size() != 0,
                    (q.size() != 0) ? q[0] : z);
            chk("rnd.cnt32", 64'(cnt0), 64'(mcnt));
            chk("rnd.cnt4", 64'(cnt1), 64'(mcnt[3:0]));
            @(posedge clk);
            if (!r) begin
                q.delete();
                mcnt = 32'd0;
            end else begin
                acc = m && q.size() < 2;
                drn = w && q.size() != 0;
                if (drn) mcnt = mcnt + 32'd1;
                if (f) q.delete();
                else begin
                    if (drn) void'(q.pop_front());
                    if (acc) q.push_back(e);
                end
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
